// File: rtl/clk_gate_ctrl.sv
// Clock gate controller: sequences the enable of a downstream clock gating
// cell through IDLE -> WAKE -> ACTIVE -> HOLD -> IDLE, and reports how many
// cycles the gate was enabled.
//
// Legal WAKE_CYC range is 1..15; the wake counter is 4 bits wide.
//
// All outputs are Moore outputs taken straight from flops. The next-state
// value of each output is computed from the next FSM state, so gate_en_o
// changes on the same edge as the state and never passes through logic
// after the register.
module clk_gate_ctrl #(
  parameter int unsigned WAKE_CYC  = 2,
  parameter int unsigned TMO_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 busy_i,
  input  logic [TMO_WIDTH-1:0] idle_tmo_i,
  input  logic                 cnt_clr_i,
  output logic                 gate_en_o,
  output logic                 clk_rdy_o,
  output logic [15:0]          act_cnt_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // WAKE lasts WAKE_CYC cycles: the counter is loaded with WAKE_CYC-1 on
  // entry and the exit to ACTIVE happens on the edge that sees it at zero.
  localparam logic [3:0]           WAKE_LOAD = 4'(WAKE_CYC - 1);
  localparam logic [3:0]           WAKE_ONE  = 4'd1;
  localparam logic [TMO_WIDTH-1:0] HOLD_ONE  = TMO_WIDTH'(1);

  state_t               state_q, state_d;
  logic [3:0]           wake_q, wake_d;
  logic [TMO_WIDTH-1:0] hold_q, hold_d;
  logic                 gate_en_q, gate_en_d;
  logic                 clk_rdy_q, clk_rdy_d;
  logic [15:0]          act_cnt_q, act_cnt_d;

  // Next-state, timer and output decode.
  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        // busy_i has no meaning while the domain is clock-gated.
        if (req_i) begin
          state_d = ST_WAKE;
          wake_d  = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // The wake sequence always completes, even if req_i drops.
        if (wake_q == 4'd0) begin
          state_d = ST_ACTIVE;
        end else begin
          wake_d = wake_q - WAKE_ONE;
        end
      end
      ST_ACTIVE: begin
        if (!req_i && !busy_i) begin
          state_d = ST_HOLD;
          hold_d  = idle_tmo_i;
        end
      end
      ST_HOLD: begin
        // Activity wins over an expiring timer.
        if (req_i || busy_i) begin
          state_d = ST_ACTIVE;
        end else if (hold_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gate_en_d = (state_d != ST_IDLE);
    clk_rdy_d = (state_d == ST_ACTIVE) || (state_d == ST_HOLD);
  end

  // Activity counter: clear beats increment, saturates at all-ones.
  always_comb begin
    act_cnt_d = act_cnt_q;
    if (cnt_clr_i) begin
      act_cnt_d = 16'd0;
    end else if (gate_en_q && (act_cnt_q != 16'hFFFF)) begin
      act_cnt_d = act_cnt_q + 16'd1;
    end
  end

  // State, timers and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wake_q    <= 4'd0;
      hold_q    <= '0;
      gate_en_q <= 1'b0;
      clk_rdy_q <= 1'b0;
      act_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      wake_q    <= wake_d;
      hold_q    <= hold_d;
      gate_en_q <= gate_en_d;
      clk_rdy_q <= clk_rdy_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign gate_en_o = gate_en_q;
  assign clk_rdy_o = clk_rdy_q;
  assign act_cnt_o = act_cnt_q;
  assign state_o   = state_q;

endmodule
